// File: rtl/systolic_sequencer.sv
// Lockstep slot controller for the 8-PE systolic interpolation array: one word per SLOT_CYCLES slot.
// Latency: accept -> start_mult next cycle -> capture SLOT_CYCLES later; in_ready only in idle or last slot cycle.
module systolic_sequencer #(
    parameter int WORDLENGTH  = 16,
    parameter int NUM_PE      = 8,
    parameter int IDX_W       = 3,
    parameter int SLOT_CYCLES = 30
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [WORDLENGTH-1:0] in_word,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORDLENGTH-1:0] pe_word,
    output logic                  start_mult,
    output logic                  capture,
    output logic [IDX_W-1:0]      word_index,
    output logic [NUM_PE-1:0]     first_term,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      out_select,
    output logic                  busy
);

    localparam int CNT_W  = $clog2(SLOT_CYCLES);
    localparam int WARM_W = $clog2(NUM_PE + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(NUM_PE);
    localparam logic [WARM_W-1:0] WARM_RDY = WARM_W'(NUM_PE - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                r_state, w_state_n;
    logic [CNT_W-1:0]      r_cnt, w_cnt_n;
    logic [WARM_W-1:0]     r_warm, w_warm_n;
    logic [WORDLENGTH-1:0] r_pe_word, w_pe_word_n;
    logic [IDX_W-1:0]      r_widx, w_widx_n;
    logic [IDX_W-1:0]      r_osel, w_osel_n;
    logic [NUM_PE-1:0]     r_first, w_first_n;
    logic                  r_start, w_start_n;
    logic                  r_capture, w_capture_n;
    logic                  r_ov, w_ov_n;
    logic                  r_busy, w_busy_n;
    logic                  w_last;
    logic                  w_ready;
    logic                  w_hs;

    assign w_last  = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    // Held low while reset is asserted so nothing is offered an accept during the abort.
    assign w_ready = reset && !clear && ((r_state == S_IDLE) || w_last);
    assign w_hs    = in_valid && w_ready;

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_warm_n    = r_warm;
        w_pe_word_n = r_pe_word;
        w_widx_n    = r_widx;
        w_osel_n    = r_osel;
        w_ov_n      = 1'b0;
        if (clear) begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_widx_n  = '0;
            w_warm_n  = '0;
        end else begin
            if (r_state == S_RUN) begin
                if (w_last) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                    w_widx_n  = r_widx + 1'b1;
                    if (r_warm != WARM_MAX)
                        w_warm_n = r_warm + 1'b1;
                    // The PE after w has now seen all NUM_PE terms since its restart.
                    if (r_warm >= WARM_RDY) begin
                        w_ov_n   = 1'b1;
                        w_osel_n = r_widx + 1'b1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            if (w_hs) begin
                w_state_n   = S_RUN;
                w_cnt_n     = '0;
                w_pe_word_n = in_word;
            end
        end
        w_start_n   = w_hs;
        w_busy_n    = (w_state_n == S_RUN);
        w_capture_n = w_busy_n && (w_cnt_n == LAST_CNT);
        w_first_n   = w_busy_n ? (NUM_PE'(1) << w_widx_n) : '0;
    end

    always_ff @(posedge clk30x or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_warm    <= '0;
            r_pe_word <= '0;
            r_widx    <= '0;
            r_osel    <= '0;
            r_first   <= '0;
            r_start   <= 1'b0;
            r_capture <= 1'b0;
            r_ov      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_warm    <= w_warm_n;
            r_pe_word <= w_pe_word_n;
            r_widx    <= w_widx_n;
            r_osel    <= w_osel_n;
            r_first   <= w_first_n;
            r_start   <= w_start_n;
            r_capture <= w_capture_n;
            r_ov      <= w_ov_n;
            r_busy    <= w_busy_n;
        end
    end

    assign in_ready   = w_ready;
    assign pe_word    = r_pe_word;
    assign start_mult = r_start;
    assign capture    = r_capture;
    assign word_index = r_widx;
    assign first_term = r_first;
    assign out_valid  = r_ov;
    assign out_select = r_osel;
    assign busy       = r_busy;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: scoreboard of accepted words, slot indices and expected out_select values.
module tb_systolic_sequencer;

    localparam int WL   = 16;
    localparam int NPE  = 8;
    localparam int IW   = 3;
    localparam int SLOT = 30;

    logic           clk30x = 1'b0;
    logic           reset  = 1'b0;
    logic           clear  = 1'b0;
    logic [WL-1:0]  in_word = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [WL-1:0]  pe_word;
    logic           start_mult;
    logic           capture;
    logic [IW-1:0]  word_index;
    logic [NPE-1:0] first_term;
    logic           out_valid;
    logic [IW-1:0]  out_select;
    logic           busy;

    systolic_sequencer #(.WORDLENGTH(WL), .NUM_PE(NPE), .IDX_W(IW), .SLOT_CYCLES(SLOT)) dut (
        .clk30x(clk30x), .reset(reset), .clear(clear), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .pe_word(pe_word), .start_mult(start_mult), .capture(capture),
        .word_index(word_index), .first_term(first_term), .out_valid(out_valid),
        .out_select(out_select), .busy(busy)
    );

    always #5 clk30x = ~clk30x;

    int n_cmp = 0;
    int n_err = 0;

    logic [WL-1:0] q_word[$];
    int            q_idx[$];
    int            q_osel[$];
    int            m_idx  = 0;
    int            m_warm = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: everything sampled on the falling edge.
    int            cyc = 0, last_start = -100, last_cap = -100, since = 0, cur_idx = 0;
    logic [WL-1:0] cur_word = '0;
    always @(negedge clk30x) begin
        if (reset) begin
            cyc++;
            if (start_mult) begin
                if (last_cap == cyc - 1)
                    chk("b2b_gap", 32'(cyc - last_start), 32'(SLOT));
                if (q_word.size() == 0) begin
                    chk("start_unexp", 32'd1, 32'd0);
                end else begin
                    cur_word = q_word.pop_front();
                    cur_idx  = q_idx.pop_front();
                    chk("pe_word_start", 32'(pe_word), 32'(cur_word));
                    chk("word_index", 32'(word_index), 32'(cur_idx));
                end
                last_start = cyc;
                since = 0;
            end else begin
                since++;
            end
            if (busy) begin
                chk("pe_word_hold", 32'(pe_word), 32'(cur_word));
                chk("first_term", 32'(first_term), 32'(1) << cur_idx);
            end
            if (capture) begin
                chk("capture_pos", 32'(since), 32'(SLOT - 1));
                last_cap = cyc;
            end
            if (out_valid) begin
                chk("ov_after_cap", 32'(cyc - last_cap), 32'd1);
                if (q_osel.size() == 0) chk("ov_unexp", 32'd1, 32'd0);
                else chk("out_select", 32'(out_select), 32'(q_osel.pop_front()));
            end
        end
    end

    task automatic send(input logic [WL-1:0] w, input bit abort);
        int t = 0;
        @(negedge clk30x);
        in_word  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk30x);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk30x);
            q_word.push_back(w);
            q_idx.push_back(m_idx);
            if (!abort) begin
                if (m_warm >= NPE - 1) q_osel.push_back((m_idx + 1) % NPE);
                if (m_warm < NPE) m_warm++;
                m_idx = (m_idx + 1) % NPE;
            end
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk30x);
        while (busy && t < 100) begin
            @(negedge clk30x);
            t++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_pe_word"}, 32'(pe_word), 32'd0);
        chk({tag, "_pulses"}, {29'd0, start_mult, capture, out_valid}, 32'd0);
        chk({tag, "_index"}, {26'd0, word_index, out_select}, 32'd0);
        chk({tag, "_first_busy"}, {23'd0, first_term, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk30x);
        reset = 1'b0;
        in_valid = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk30x);
        chk_reset_vals("rst");
        reset = 1'b1;
        m_idx = 0;
        m_warm = 0;
        #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
    endtask

    task automatic single_word_check(input string tag);
        send(16'h1234, 1'b0);
        wait_idle();
        chk({tag, "_idx"}, 32'(word_index), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_first"}, 32'(first_term), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1: reset and one isolated word.
        do_reset();
        single_word_check("single");

        // Scenario 2: ten words back-to-back; out_select 0,1,2 after captures 8,9,10.
        do_reset();
        for (int i = 0; i < 10; i++) send(16'hA000 + 16'(i * 16'h0111), 1'b0);
        wait_idle();
        chk("b2b_idx", 32'(word_index), 32'd2);

        // Scenario 3: 50-cycle gap after word 3 keeps warm-up progress.
        do_reset();
        for (int i = 0; i < 3; i++) send(16'h3000 + 16'(i), 1'b0);
        wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk30x);
            if (i == 0 || i == 49) begin
                chk("gap_ready", 32'(in_ready), 32'd1);
                chk("gap_busy", 32'(busy), 32'd0);
                chk("gap_idx", 32'(word_index), 32'd3);
            end
        end
        for (int i = 0; i < 7; i++) send(16'h4000 + 16'(i * 7), 1'b0);
        wait_idle();

        // Scenario 4: clear at cnt=15 of slot 5 with a word on offer.
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h5500 + 16'(i), 1'b0);
        send(16'h5A5A, 1'b1);
        repeat (16) @(negedge clk30x);
        clear    = 1'b1;
        in_word  = 16'hDEAD;
        in_valid = 1'b1;
        #1 chk("clear_ready", 32'(in_ready), 32'd0);
        @(posedge clk30x);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        m_idx  = 0;
        m_warm = 0;
        @(negedge clk30x);
        chk("clear_busy", 32'(busy), 32'd0);
        chk("clear_idx", 32'(word_index), 32'd0);
        chk("clear_pe_word", 32'(pe_word), 32'h5A5A);
        for (int i = 0; i < 8; i++) send(16'h6600 + 16'(i), 1'b0);
        wait_idle();

        // Scenario 5: asynchronous reset at cnt=10, then a clean single word.
        do_reset();
        send(16'h7777, 1'b1);
        repeat (11) @(negedge clk30x);
        #1 reset = 1'b0;
        #1 chk_reset_vals("arst");
        m_idx  = 0;
        m_warm = 0;
        repeat (2) @(negedge clk30x);
        reset = 1'b1;
        single_word_check("post_arst");

        repeat (3) @(negedge clk30x);
        chk("osel_left", 32'(q_osel.size()), 32'd0);
        chk("word_left", 32'(q_word.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Sequencer for the 8-element systolic interpolation array (systolic_PE0..7). It accepts non-uniform sample words through a valid/ready handshake and broadcasts each word to every PE for one fixed multiply slot. It drives the shared word index, the start-of-multiply pulse and the end-of-slot capture strobe, and flags which PE holds a completed 8-term sum. It replaces the free-running per-PE counters, so all PEs step in lockstep from one controller.

## Interface
- WORDLENGTH, 16, sample/coefficient word width
- NUM_PE, 8, number of PEs and word_index modulus (power of two)
- IDX_W, 3, width of word_index/out_select (log2 NUM_PE)
- SLOT_CYCLES, 30, clk30x cycles per word slot (≥4); covers sequential mult latency
- clk30x  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort/restart, active-high
- in_word  in  WORDLENGTH  incoming sample value
- in_valid  in  1  in_word valid
- in_ready  out  1  sequencer accepts in_word this cycle
- pe_word  out  WORDLENGTH  word broadcast to all PEs, stable for the whole slot
- start_mult  out  1  one-cycle pulse, first cycle of each slot
- capture  out  1  one-cycle pulse, last cycle of slot; PEs latch accumulator
- word_index  out  IDX_W  index of word in current slot, mod NUM_PE
- first_term  out  NUM_PE  one-hot; bit p = 1 when word_index==p (PE p restarts accumulation)
- out_valid  out  1  one-cycle pulse: PE out_select holds a complete sum
- out_select  out  IDX_W  PE whose output is complete
- busy  out  1  a slot is in progress

## Operation
- States: IDLE, RUN.
- IDLE: in_ready=1. Handshake (in_valid & in_ready) → latch in_word into pe_word, slot counter cnt=0, state RUN.
- RUN: cnt increments each cycle 0..SLOT_CYCLES-1. start_mult=1 iff cnt==0. capture=1 iff cnt==SLOT_CYCLES-1. in_ready=1 only in that last cycle.
- End of slot (cnt==SLOT_CYCLES-1): word_index ← word_index+1 mod NUM_PE on the next edge. If a handshake occurs in the same cycle → new slot starts back-to-back (cnt=0, new pe_word); else → IDLE.
- first_term derived from word_index, valid whenever busy=1; all zeros in IDLE.
- Warm-up: a saturating counter (0..NUM_PE) increments on each capture. At a capture with word_index=w and the counter already ≥ NUM_PE-1 (i.e. this is the NUM_PE-th or later capture), the next cycle gives out_valid=1 and out_select=(w+1) mod NUM_PE.
- clear=1: next edge → IDLE, word_index=0, warm-up=0, no out_valid. pe_word is held. in_ready=0 while clear=1, and clear overrides any handshake in the same cycle.
- No input buffering: a word offered while in_ready=0 waits. in_word must stay stable while in_valid=1.

## Timing
- Reset (asserted) values: state IDLE, in_ready=0, pe_word=0, start_mult=0, capture=0, word_index=0, first_term=0, out_valid=0, out_select=0, busy=0, cnt=0, warm-up=0. in_ready rises in the first cycle after reset deasserts.
- Reset mid-slot aborts immediately (asynchronous). No partial pulses after release.
- Accept at edge T → start_mult high cycle T+1 → capture high cycle T+SLOT_CYCLES → out_valid (if warm) high cycle T+SLOT_CYCLES+1.
- Back-to-back throughput: one word per SLOT_CYCLES cycles, with no idle gap.
- busy=1 from cycle T+1 through the capture cycle inclusive.
- word_index wrap: 7→0 at NUM_PE=8. out_select for w=7 is 0.
- All outputs except in_ready are registered. in_ready is combinational from state/cnt/clear, gated low during reset.

## Test plan
- Reset, then one word 0x1234: in_ready=1 idle. Expect start_mult at cycle+1, capture at cycle+30, word_index 0→1, no out_valid, return to IDLE (busy=0).
- 10 back-to-back words with in_valid held high: exactly 30 cycles between start_mult pulses. out_valid first after the 8th capture with out_select=0, then after the 9th (out_select=1) and 10th (out_select=2).
- first_term check across 9 slots: one-hot bits 0..7 then bit 0 again, and pe_word matches each accepted word for all 30 cycles.
- in_valid low for 50 cycles between words 3 and 4: in_ready stays 1, busy=0, word_index holds at 3, and warm-up is not lost.
- clear at cnt=15 of slot 5 while in_valid=1: no capture, IDLE next cycle, word_index=0. The next 7 captures give no out_valid; the 8th gives out_select=0.
- Async reset asserted at cnt=10: all outputs go to reset values without a clock edge. After release, the first accepted word behaves as in scenario 1.
